// File: rtl/game_flow_ctrl.sv
// Flood-It game sequencer: setup menu, move-budget division, move counting and win/lose.
// Drives the 7-segment display configuration and pulses START_GAME to the board engine.
module game_flow_ctrl #(
    parameter int MIN_SIZE   = 2,
    parameter int MAX_SIZE   = 20,
    parameter int DEF_SIZE   = 14,
    parameter int MIN_COLORS = 3,
    parameter int MAX_COLORS = 9,
    parameter int DEF_COLORS = 6,
    parameter int BUDGET_NUM = 50,
    parameter int BUDGET_DEN = 168
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       BTN_UP,
    input  logic       BTN_DOWN,
    input  logic       BTN_SEL,
    input  logic       MOVE_DONE,
    input  logic       SOLVED,
    output logic [4:0] SIZE,
    output logic [3:0] COLOR_NUM,
    output logic       selecting,
    output logic       sORc,
    output logic       MODE,
    output logic [7:0] TRIES,
    output logic [7:0] TOTAL_TRIES,
    output logic       START_GAME,
    output logic       GAME_WON,
    output logic       GAME_LOST
);

    // state     | meaning
    // SEL_SIZE  | menu: editing board edge
    // SEL_COLOR | menu: editing colour count
    // CALC      | load, then divide budget by repeated subtraction
    // PLAY      | counting moves
    // WON       | board solved within budget
    // LOST      | budget exhausted
    typedef enum logic [2:0] {
        SEL_SIZE, SEL_COLOR, CALC, PLAY, WON, LOST
    } state_t;

    localparam logic [4:0]  SZ_MIN  = 5'(MIN_SIZE);
    localparam logic [4:0]  SZ_MAX  = 5'(MAX_SIZE);
    localparam logic [4:0]  SZ_DEF  = 5'(DEF_SIZE);
    localparam logic [3:0]  CL_MIN  = 4'(MIN_COLORS);
    localparam logic [3:0]  CL_MAX  = 4'(MAX_COLORS);
    localparam logic [3:0]  CL_DEF  = 4'(DEF_COLORS);
    localparam logic [13:0] NUM     = 14'(BUDGET_NUM);
    localparam logic [13:0] DEN     = 14'(BUDGET_DEN);
    localparam logic [7:0]  TRY_MAX = 8'd99;

    state_t      state;
    logic [2:0]  btn_s1, btn_s2, btn_prev;
    logic [2:0]  btn_edge;
    logic        up_e, dn_e, sel_e;
    logic [13:0] calc_n;
    logic [7:0]  calc_q;
    logic        calc_load;
    logic [7:0]  tries_inc;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_prev <= '0;
        end else begin
            btn_s1   <= {BTN_SEL, BTN_DOWN, BTN_UP};
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
        end
    end

    // Simultaneous UP and DOWN cancel each other out
    assign btn_edge  = btn_s2 & ~btn_prev;
    assign up_e      = btn_edge[0] & ~btn_edge[1];
    assign dn_e      = btn_edge[1] & ~btn_edge[0];
    assign sel_e     = btn_edge[2];
    assign tries_inc = (TRIES >= TRY_MAX) ? TRY_MAX : TRIES + 8'd1;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= SEL_SIZE;
            SIZE        <= SZ_DEF;
            COLOR_NUM   <= CL_DEF;
            TRIES       <= '0;
            TOTAL_TRIES <= '0;
            selecting   <= 1'b1;
            sORc        <= 1'b1;
            MODE        <= 1'b0;
            START_GAME  <= 1'b0;
            GAME_WON    <= 1'b0;
            GAME_LOST   <= 1'b0;
            calc_n      <= '0;
            calc_q      <= '0;
            calc_load   <= 1'b0;
        end else begin
            START_GAME <= 1'b0;
            case (state)
                SEL_SIZE: begin
                    if (sel_e) begin
                        state <= SEL_COLOR;
                        sORc  <= 1'b0;
                    end else if (up_e) begin
                        SIZE <= (SIZE >= SZ_MAX) ? SZ_MIN : SIZE + 5'd1;
                    end else if (dn_e) begin
                        SIZE <= (SIZE <= SZ_MIN) ? SZ_MAX : SIZE - 5'd1;
                    end
                end
                SEL_COLOR: begin
                    if (sel_e) begin
                        state     <= CALC;
                        selecting <= 1'b0;
                        calc_load <= 1'b1;
                    end else if (up_e) begin
                        COLOR_NUM <= (COLOR_NUM >= CL_MAX) ? CL_MIN : COLOR_NUM + 4'd1;
                    end else if (dn_e) begin
                        COLOR_NUM <= (COLOR_NUM <= CL_MIN) ? CL_MAX : COLOR_NUM - 4'd1;
                    end
                end
                CALC: begin
                    if (calc_load) begin
                        calc_n    <= NUM * {9'd0, SIZE} * {10'd0, COLOR_NUM};
                        calc_q    <= '0;
                        calc_load <= 1'b0;
                    end else if (calc_n >= DEN) begin
                        calc_n <= calc_n - DEN;
                        calc_q <= calc_q + 8'd1;
                    end else begin
                        TOTAL_TRIES <= (calc_q > TRY_MAX) ? TRY_MAX : calc_q;
                        TRIES       <= '0;
                        START_GAME  <= 1'b1;
                        MODE        <= 1'b1;
                        state       <= PLAY;
                    end
                end
                PLAY: begin
                    // A solve on the budget-exhausting move still counts as a win
                    if (SOLVED) begin
                        if (MOVE_DONE) TRIES <= tries_inc;
                        state    <= WON;
                        GAME_WON <= 1'b1;
                    end else if (MOVE_DONE) begin
                        TRIES <= tries_inc;
                        if (tries_inc >= TOTAL_TRIES) begin
                            state     <= LOST;
                            GAME_LOST <= 1'b1;
                        end
                    end
                end
                WON, LOST: begin
                    if (sel_e) begin
                        state     <= SEL_SIZE;
                        TRIES     <= '0;
                        selecting <= 1'b1;
                        sORc      <= 1'b1;
                        MODE      <= 1'b0;
                        GAME_WON  <= 1'b0;
                        GAME_LOST <= 1'b0;
                    end
                end
                default: state <= SEL_SIZE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: menu wrap, budget division latency, play outcomes, async reset.
module tb_game_flow_ctrl;

    logic       CLOCK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       BTN_UP = 1'b0, BTN_DOWN = 1'b0, BTN_SEL = 1'b0;
    logic       MOVE_DONE = 1'b0, SOLVED = 1'b0;
    logic [4:0] SIZE;
    logic [3:0] COLOR_NUM;
    logic       selecting, sORc, MODE;
    logic [7:0] TRIES, TOTAL_TRIES;
    logic       START_GAME, GAME_WON, GAME_LOST;

    int n_checks = 0;
    int n_fail   = 0;

    game_flow_ctrl dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN), .BTN_SEL(BTN_SEL),
        .MOVE_DONE(MOVE_DONE), .SOLVED(SOLVED),
        .SIZE(SIZE), .COLOR_NUM(COLOR_NUM),
        .selecting(selecting), .sORc(sORc), .MODE(MODE),
        .TRIES(TRIES), .TOTAL_TRIES(TOTAL_TRIES),
        .START_GAME(START_GAME), .GAME_WON(GAME_WON), .GAME_LOST(GAME_LOST)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    // mask bit0 = UP, bit1 = DOWN, bit2 = SEL
    task automatic press(input logic [2:0] mask);
        BTN_UP   = mask[0];
        BTN_DOWN = mask[1];
        BTN_SEL  = mask[2];
        repeat (4) tick();
        BTN_UP   = 1'b0;
        BTN_DOWN = 1'b0;
        BTN_SEL  = 1'b0;
        repeat (3) tick();
    endtask

    task automatic move(input logic done, input logic solved);
        MOVE_DONE = done;
        SOLVED    = solved;
        tick();
        MOVE_DONE = 1'b0;
        SOLVED    = 1'b0;
        tick();
    endtask

    // Called in SEL_COLOR; latency counted from the cycle that leaves the menu
    task automatic run_calc(input string tag, input int lat, input int tot);
        int n;
        BTN_SEL = 1'b1;
        n = 0;
        while (selecting !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        BTN_SEL = 1'b0;
        n = 0;
        while (START_GAME !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, lat);
        check({tag, "_total"}, int'(TOTAL_TRIES), tot);
        check({tag, "_mode"}, int'(MODE), 1);
        tick();
        check({tag, "_start_pulse_len"}, int'(START_GAME), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_size"}, int'(SIZE), 14);
        check({tag, "_colors"}, int'(COLOR_NUM), 6);
        check({tag, "_selecting"}, int'(selecting), 1);
        check({tag, "_sorc"}, int'(sORc), 1);
        check({tag, "_mode"}, int'(MODE), 0);
        check({tag, "_tries"}, int'(TRIES), 0);
        check({tag, "_total"}, int'(TOTAL_TRIES), 0);
        check({tag, "_start"}, int'(START_GAME), 0);
        check({tag, "_won"}, int'(GAME_WON), 0);
        check({tag, "_lost"}, int'(GAME_LOST), 0);
    endtask

    initial begin
        logic seen_start;

        repeat (3) tick();
        RESET_N = 1'b1;
        tick();
        check_reset_vals("reset");

        // Size wrap
        repeat (6) press(3'b001);
        check("size_up_to_max", int'(SIZE), 20);
        press(3'b001);
        check("size_wrap_up", int'(SIZE), 2);
        press(3'b010);
        check("size_wrap_down", int'(SIZE), 20);
        press(3'b011);
        check("size_up_down_same", int'(SIZE), 20);
        repeat (6) press(3'b010);
        check("size_back_14", int'(SIZE), 14);

        press(3'b100);
        check("sel_color_sorc", int'(sORc), 0);
        check("sel_color_selecting", int'(selecting), 1);

        // Colour wrap
        repeat (3) press(3'b001);
        check("color_max", int'(COLOR_NUM), 9);
        press(3'b001);
        check("color_wrap_up", int'(COLOR_NUM), 3);
        press(3'b010);
        check("color_wrap_down", int'(COLOR_NUM), 9);
        repeat (3) press(3'b010);
        check("color_back_6", int'(COLOR_NUM), 6);

        run_calc("calc_14_6", 27, 25);
        check("play_selecting", int'(selecting), 0);

        // Budget exhausted without solve
        repeat (24) move(1'b1, 1'b0);
        check("play_tries_24", int'(TRIES), 24);
        check("play_not_lost_24", int'(GAME_LOST), 0);
        move(1'b1, 1'b0);
        check("lost_tries", int'(TRIES), 25);
        check("lost_flag", int'(GAME_LOST), 1);
        move(1'b0, 1'b1);
        check("lost_ignores_solved", int'(GAME_WON), 0);
        move(1'b1, 1'b0);
        check("lost_tries_frozen", int'(TRIES), 25);
        press(3'b001);
        check("lost_ignores_up", int'(SIZE), 14);
        press(3'b100);
        check("lost_sel_selecting", int'(selecting), 1);
        check("lost_sel_tries", int'(TRIES), 0);
        check("lost_sel_size", int'(SIZE), 14);
        check("lost_sel_lost", int'(GAME_LOST), 0);

        // Solve on the final budgeted move
        press(3'b100);
        run_calc("calc_again", 27, 25);
        repeat (24) move(1'b1, 1'b0);
        move(1'b1, 1'b1);
        check("won_tries", int'(TRIES), 25);
        check("won_flag", int'(GAME_WON), 1);
        check("won_not_lost", int'(GAME_LOST), 0);
        press(3'b100);
        check("won_sel_mode", int'(MODE), 0);
        check("won_sel_size", int'(SIZE), 14);
        check("won_sel_colors", int'(COLOR_NUM), 6);
        check("won_sel_tries", int'(TRIES), 0);

        // Largest board
        repeat (6) press(3'b001);
        press(3'b100);
        repeat (3) press(3'b001);
        run_calc("calc_20_9", 55, 53);
        move(1'b0, 1'b1);
        check("solve_no_move_won", int'(GAME_WON), 1);
        check("solve_no_move_tries", int'(TRIES), 0);
        press(3'b100);

        // Smallest board
        press(3'b001);
        check("min_size", int'(SIZE), 2);
        press(3'b100);
        press(3'b001);
        check("min_colors", int'(COLOR_NUM), 3);
        run_calc("calc_2_3", 3, 1);
        move(1'b1, 1'b0);
        check("budget1_tries", int'(TRIES), 1);
        check("budget1_lost", int'(GAME_LOST), 1);
        press(3'b100);

        // Reset in the middle of CALC
        press(3'b100);
        press(3'b001);
        press(3'b001);
        press(3'b001);
        press(3'b001);
        check("pre_calc_colors", int'(COLOR_NUM), 7);
        BTN_SEL = 1'b1;
        for (int i = 0; i < 10 && selecting !== 1'b0; i++) tick();
        BTN_SEL = 1'b0;
        repeat (2) tick();
        RESET_N = 1'b0;
        #2;
        check_reset_vals("rst_calc");
        tick();
        RESET_N = 1'b1;
        seen_start = 1'b0;
        repeat (40) begin
            tick();
            seen_start |= START_GAME;
        end
        check("rst_calc_no_start", int'(seen_start), 0);

        // Reset in the middle of PLAY
        press(3'b100);
        run_calc("calc_pre_rst", 27, 25);
        repeat (3) move(1'b1, 1'b0);
        check("pre_rst_tries", int'(TRIES), 3);
        RESET_N = 1'b0;
        #2;
        check_reset_vals("rst_play");
        tick();
        RESET_N = 1'b1;
        seen_start = 1'b0;
        repeat (40) begin
            tick();
            seen_start |= START_GAME;
        end
        check("rst_play_no_start", int'(seen_start), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
